pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and pipeline-control unit for the 5-stage core (fetch/decode/execute/memory/writeback).
- Selects operand bypass data for execute.
- Generates load-use stalls, branch flushes and halt drain from the per-stage write-back tags.
- Replaces the ad-hoc rst-driven NOP injection and unconditional pipeline advance with one FSM.
- Sits beside the pipeline registers and drives their hold and flush controls.

Parameters:
DATA_W, 32, operand/result width
REG_ADDR_W, 3, register-specifier width (2**REG_ADDR_W registers, all writable, no hardwired zero)
LOAD_LAT, 1, bubble cycles inserted on a load-use hazard (1..7)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dec_src_a  in  REG_ADDR_W  decode-stage source A specifier
dec_src_b  in  REG_ADDR_W  decode-stage source B specifier
dec_use_a  in  1  decode instruction reads source A
dec_use_b  in  1  decode instruction reads source B
dec_halt  in  1  decode holds a halt instruction
ex_src_a  in  REG_ADDR_W  execute-stage source A (registered copy)
ex_src_b  in  REG_ADDR_W  execute-stage source B
ex_rf_a  in  DATA_W  register-file value of A latched into execute
ex_rf_b  in  DATA_W  register-file value of B latched into execute
mem_wr_reg / mem_wr_en / mem_data  in  REG_ADDR_W/1/DATA_W  memory-stage destination, enable, ALU result
ex_wr_reg / ex_wr_en / ex_mem_read  in  REG_ADDR_W/1/1  execute-stage destination, enable, is-load
wb_wr_reg / wb_wr_en / wb_data  in  REG_ADDR_W/1/DATA_W  writeback destination, enable, final data
branch_taken  in  1  execute resolved a taken jump/branch this cycle
wb_halt  in  1  halt instruction has reached writeback
hold_fd  out  1  freeze PC and fetch/decode register
bubble_dx  out  1  load NOP into decode/execute register
flush_fd  out  1  replace fetch/decode contents with NOP
flush_dx  out  1  replace decode/execute contents with NOP
op_a / op_b  out  DATA_W  forwarded operands to execute
fwd_a_sel / fwd_b_sel  out  2  0=RF, 1=MEM, 2=WB (debug/coverage)
halted  out  1  core fully drained and stopped

Behaviour:
- Reset (async, rst=1): state RUN, bubble counter 0, halted 0. All control outputs are 0. op_a=ex_rf_a and op_b=ex_rf_b combinationally.
- Forwarding, combinational, per operand X:
  - MEM match (mem_wr_en && mem_wr_reg==ex_src_X) wins over WB match (wb_wr_en && wb_wr_reg==ex_src_X).
  - With neither match, the RF value is used.
  - WB forwarding also covers same-cycle register-file write/read.
- Load-use detect (RUN only): ex_mem_read && ex_wr_en && ((dec_use_a && ex_wr_reg==dec_src_a) || (dec_use_b && ex_wr_reg==dec_src_b)).
- FSM states: RUN, STALL, DRAIN, HALTED.
  - RUN:
    - branch_taken: flush_fd=flush_dx=1 for that cycle and stay in RUN. Branch beats load-use and halt detection in the same cycle.
    - else load-use: hold_fd=bubble_dx=1 this cycle. If LOAD_LAT>1, go to STALL with counter=LOAD_LAT-1.
    - else dec_halt: hold_fd=1, go to DRAIN.
  - STALL: hold_fd=bubble_dx=1. Counter decrements each cycle; at 1, return to RUN.
    - branch_taken in STALL: flush both, counter cleared, return to RUN.
  - DRAIN: hold_fd=1 every cycle, so nothing younger than the halt enters. Stay until wb_halt=1, then go to HALTED.
  - HALTED: hold_fd=1, halted=1. Sticky until rst.
- A halt in the wrong path is flushed by branch_taken before decode reaches DRAIN.
- rst mid-stall or mid-drain returns to RUN immediately; no residual hold.

Optional Feature:
PIPE_HAZARD_CTRL_FWD_EN
- Defined: forwarding as above.
- Undefined: op_X = ex_rf_X and fwd_X_sel=0 always. Any decode source matching an enabled ex/mem/wb destination is treated as a hazard: hold_fd=bubble_dx=1, re-evaluated each cycle until no match remains. LOAD_LAT is then unused.

Test Plan:
1. mem_wr_en=1, mem_wr_reg=3, mem_data=32'h11, wb_wr_en=1, wb_wr_reg=3, wb_data=32'h22, ex_src_a=3 -> op_a=32'h11, fwd_a_sel=1.
2. LOAD_LAT=2, ex_mem_read=1, ex_wr_reg=5, dec_src_b=5, dec_use_b=1 -> hold_fd=bubble_dx=1 for exactly 2 cycles, then 0.
3. Same cycle: load-use and branch_taken=1 -> flush_fd=flush_dx=1, hold_fd=0, FSM stays RUN.
4. dec_halt=1; wb_halt asserted 3 cycles later -> hold_fd=1 throughout, halted rises the cycle after wb_halt and stays 1.
5. rst pulsed while in STALL (counter=1) -> all outputs 0 asynchronously; RUN after release.
6. Macro undefined, ex_wr_en=1, ex_wr_reg=2, dec_src_a=2 (non-load) -> stall until the tag leaves writeback, op_a=ex_rf_a.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline (master) and its hazard/forwarding controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3
);
  logic [REG_ADDR_W-1:0] dec_src_a;
  logic [REG_ADDR_W-1:0] dec_src_b;
  logic                  dec_use_a;
  logic                  dec_use_b;
  logic                  dec_halt;
  logic [REG_ADDR_W-1:0] ex_src_a;
  logic [REG_ADDR_W-1:0] ex_src_b;
  logic [DATA_W-1:0]     ex_rf_a;
  logic [DATA_W-1:0]     ex_rf_b;
  logic [REG_ADDR_W-1:0] mem_wr_reg;
  logic                  mem_wr_en;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] ex_wr_reg;
  logic                  ex_wr_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] wb_wr_reg;
  logic                  wb_wr_en;
  logic [DATA_W-1:0]     wb_data;
  logic                  branch_taken;
  logic                  wb_halt;
  logic                  hold_fd;
  logic                  bubble_dx;
  logic                  flush_fd;
  logic                  flush_dx;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  halted;

  modport master (
    output dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_halt,
           ex_src_a, ex_src_b, ex_rf_a, ex_rf_b,
           mem_wr_reg, mem_wr_en, mem_data,
           ex_wr_reg, ex_wr_en, ex_mem_read,
           wb_wr_reg, wb_wr_en, wb_data, branch_taken, wb_halt,
    input  hold_fd, bubble_dx, flush_fd, flush_dx, op_a, op_b,
           fwd_a_sel, fwd_b_sel, halted
  );

  modport slave (
    input  dec_src_a, dec_src_b, dec_use_a, dec_use_b, dec_halt,
           ex_src_a, ex_src_b, ex_rf_a, ex_rf_b,
           mem_wr_reg, mem_wr_en, mem_data,
           ex_wr_reg, ex_wr_en, ex_mem_read,
           wb_wr_reg, wb_wr_en, wb_data, branch_taken, wb_halt,
    output hold_fd, bubble_dx, flush_fd, flush_dx, op_a, op_b,
           fwd_a_sel, fwd_b_sel, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control FSM for the 5-stage core.
// Define PIPE_HAZARD_CTRL_FWD_EN to enable operand bypassing; otherwise every RAW dependency stalls.
module pipe_hazard_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz_if
);
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_use_s;
  logic        dep_hazard_s;
  logic        hold_s, bubble_s, flush_fd_s, flush_dx_s;

`ifdef PIPE_HAZARD_CTRL_FWD_EN
  // Operand bypass: the younger MEM result beats WB; WB also covers the same-cycle RF write.
  always_comb begin
    hz_if.op_a      = hz_if.ex_rf_a;
    hz_if.op_b      = hz_if.ex_rf_b;
    hz_if.fwd_a_sel = 2'd0;
    hz_if.fwd_b_sel = 2'd0;
    if (rst) begin
      hz_if.fwd_a_sel = 2'd0;
    end else if (hz_if.mem_wr_en && (hz_if.mem_wr_reg == hz_if.ex_src_a)) begin
      hz_if.op_a      = hz_if.mem_data;
      hz_if.fwd_a_sel = 2'd1;
    end else if (hz_if.wb_wr_en && (hz_if.wb_wr_reg == hz_if.ex_src_a)) begin
      hz_if.op_a      = hz_if.wb_data;
      hz_if.fwd_a_sel = 2'd2;
    end else begin
      hz_if.fwd_a_sel = 2'd0;
    end
    if (rst) begin
      hz_if.fwd_b_sel = 2'd0;
    end else if (hz_if.mem_wr_en && (hz_if.mem_wr_reg == hz_if.ex_src_b)) begin
      hz_if.op_b      = hz_if.mem_data;
      hz_if.fwd_b_sel = 2'd1;
    end else if (hz_if.wb_wr_en && (hz_if.wb_wr_reg == hz_if.ex_src_b)) begin
      hz_if.op_b      = hz_if.wb_data;
      hz_if.fwd_b_sel = 2'd2;
    end else begin
      hz_if.fwd_b_sel = 2'd0;
    end
  end

  assign load_use_s = hz_if.ex_mem_read && hz_if.ex_wr_en &&
                      ((hz_if.dec_use_a && (hz_if.ex_wr_reg == hz_if.dec_src_a)) ||
                       (hz_if.dec_use_b && (hz_if.ex_wr_reg == hz_if.dec_src_b)));
  assign dep_hazard_s = 1'b0;
`else
  assign hz_if.op_a      = hz_if.ex_rf_a;
  assign hz_if.op_b      = hz_if.ex_rf_b;
  assign hz_if.fwd_a_sel = 2'd0;
  assign hz_if.fwd_b_sel = 2'd0;
  assign load_use_s      = 1'b0;

  // Without bypassing, any in-flight writer of a decode source blocks issue until it retires.
  function automatic logic dst_hit(input logic [REG_ADDR_W-1:0] src);
    return (hz_if.ex_wr_en  && (hz_if.ex_wr_reg  == src)) ||
           (hz_if.mem_wr_en && (hz_if.mem_wr_reg == src)) ||
           (hz_if.wb_wr_en  && (hz_if.wb_wr_reg  == src));
  endfunction

  assign dep_hazard_s = (hz_if.dec_use_a && dst_hit(hz_if.dec_src_a)) ||
                        (hz_if.dec_use_b && dst_hit(hz_if.dec_src_b));
`endif

  // Next-state and pipeline control decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_s     = 1'b0;
    bubble_s   = 1'b0;
    flush_fd_s = 1'b0;
    flush_dx_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz_if.branch_taken) begin
          flush_fd_s = 1'b1;
          flush_dx_s = 1'b1;
        end else if (load_use_s) begin
          hold_s   = 1'b1;
          bubble_s = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_STALL;
            cnt_d   = LAT_M1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (dep_hazard_s) begin
          hold_s   = 1'b1;
          bubble_s = 1'b1;
        end else if (hz_if.dec_halt) begin
          hold_s  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (hz_if.branch_taken) begin
          flush_fd_s = 1'b1;
          flush_dx_s = 1'b1;
          cnt_d      = 3'd0;
          state_d    = ST_RUN;
        end else begin
          hold_s   = 1'b1;
          bubble_s = 1'b1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      ST_DRAIN: begin
        hold_s = 1'b1;
        if (hz_if.wb_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        hold_s = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and bubble-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with rst keeps combinational input paths quiet while reset is held.
  assign hz_if.hold_fd   = hold_s & ~rst;
  assign hz_if.bubble_dx = bubble_s & ~rst;
  assign hz_if.flush_fd  = flush_fd_s & ~rst;
  assign hz_if.flush_dx  = flush_dx_s & ~rst;
  assign hz_if.halted    = (state_q == ST_HALTED) & ~rst;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; covers both builds of PIPE_HAZARD_CTRL_FWD_EN.
module tb_pipe_hazard_ctrl;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.DATA_W(DW), .REG_ADDR_W(AW)) hz ();

  pipe_hazard_ctrl #(.DATA_W(DW), .REG_ADDR_W(AW), .LOAD_LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Control vector order: hold_fd, bubble_dx, flush_fd, flush_dx, halted.
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, hz.hold_fd, hz.bubble_dx, hz.flush_fd, hz.flush_dx, hz.halted}, {27'd0, exp});
  endtask

  task automatic clr();
    hz.dec_src_a = 3'd0; hz.dec_src_b = 3'd0; hz.dec_use_a = 1'b0; hz.dec_use_b = 1'b0;
    hz.dec_halt = 1'b0; hz.ex_src_a = 3'd0; hz.ex_src_b = 3'd0;
    hz.ex_rf_a = 32'hAAAA_0001; hz.ex_rf_b = 32'hBBBB_0002;
    hz.mem_wr_reg = 3'd0; hz.mem_wr_en = 1'b0; hz.mem_data = 32'h0;
    hz.ex_wr_reg = 3'd0; hz.ex_wr_en = 1'b0; hz.ex_mem_read = 1'b0;
    hz.wb_wr_reg = 3'd0; hz.wb_wr_en = 1'b0; hz.wb_data = 32'h0;
    hz.branch_taken = 1'b0; hz.wb_halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    hz.branch_taken = 1'b1;
    #2;
    chk_ctl("reset_ctl", 5'b00000);
    chk("reset_op_a", hz.op_a, 32'hAAAA_0001);
    chk("reset_sel_a", {30'd0, hz.fwd_a_sel}, 32'd0);
    tick();
    rst = 1'b0;
    clr();
    #1;
    chk_ctl("idle_ctl", 5'b00000);
    chk("idle_op_b", hz.op_b, 32'hBBBB_0002);

    tick(); clr(); hz.branch_taken = 1'b1; #1;
    chk_ctl("branch_flush", 5'b00110);
    tick(); clr(); #1;
    chk_ctl("after_branch", 5'b00000);

`ifdef PIPE_HAZARD_CTRL_FWD_EN
    // MEM beats WB on operand A; B falls back to WB then RF.
    tick(); clr();
    hz.mem_wr_en = 1'b1; hz.mem_wr_reg = 3'd3; hz.mem_data = 32'h11;
    hz.wb_wr_en = 1'b1; hz.wb_wr_reg = 3'd3; hz.wb_data = 32'h22;
    hz.ex_src_a = 3'd3; hz.ex_src_b = 3'd3; #1;
    chk("fwd_mem_op_a", hz.op_a, 32'h11);
    chk("fwd_mem_sel_a", {30'd0, hz.fwd_a_sel}, 32'd1);
    hz.mem_wr_en = 1'b0; #1;
    chk("fwd_wb_op_b", hz.op_b, 32'h22);
    chk("fwd_wb_sel_b", {30'd0, hz.fwd_b_sel}, 32'd2);
    hz.ex_src_b = 3'd4; #1;
    chk("fwd_rf_op_b", hz.op_b, 32'hBBBB_0002);
    chk("fwd_rf_sel_b", {30'd0, hz.fwd_b_sel}, 32'd0);

    // Load-use with LOAD_LAT=2: two bubble cycles even after the load moves on.
    tick(); clr();
    hz.ex_mem_read = 1'b1; hz.ex_wr_en = 1'b1; hz.ex_wr_reg = 3'd5;
    hz.dec_src_b = 3'd5; hz.dec_use_b = 1'b1; #1;
    chk_ctl("lu_cyc0", 5'b11000);
    tick(); clr(); #1;
    chk_ctl("lu_cyc1", 5'b11000);
    tick(); #1;
    chk_ctl("lu_done", 5'b00000);

    // Load-use with same-cycle branch: branch wins, FSM stays in RUN.
    tick(); clr();
    hz.ex_mem_read = 1'b1; hz.ex_wr_en = 1'b1; hz.ex_wr_reg = 3'd1;
    hz.dec_src_a = 3'd1; hz.dec_use_a = 1'b1; hz.branch_taken = 1'b1; #1;
    chk_ctl("lu_branch", 5'b00110);
    tick(); clr(); #1;
    chk_ctl("lu_branch_run", 5'b00000);

    // Reset while in STALL with counter at 1.
    tick(); clr();
    hz.ex_mem_read = 1'b1; hz.ex_wr_en = 1'b1; hz.ex_wr_reg = 3'd6;
    hz.dec_src_a = 3'd6; hz.dec_use_a = 1'b1;
    tick(); clr(); #1;
    chk_ctl("stall_before_rst", 5'b11000);
    rst = 1'b1; #1;
    chk_ctl("stall_rst_async", 5'b00000);
    rst = 1'b0;
    tick(); #1;
    chk_ctl("stall_rst_run", 5'b00000);
`else
    // No bypassing: operands stay on RF and the dependency stalls until the tag retires.
    tick(); clr();
    hz.ex_wr_en = 1'b1; hz.ex_wr_reg = 3'd2; hz.dec_src_a = 3'd2; hz.dec_use_a = 1'b1;
    hz.ex_src_a = 3'd2; hz.mem_wr_en = 1'b1; hz.mem_wr_reg = 3'd2; hz.mem_data = 32'h55; #1;
    chk_ctl("dep_ex", 5'b11000);
    chk("nofwd_op_a", hz.op_a, 32'hAAAA_0001);
    chk("nofwd_sel_a", {30'd0, hz.fwd_a_sel}, 32'd0);
    tick(); hz.ex_wr_en = 1'b0; #1;
    chk_ctl("dep_mem", 5'b11000);
    tick(); hz.mem_wr_en = 1'b0; hz.wb_wr_en = 1'b1; hz.wb_wr_reg = 3'd2; #1;
    chk_ctl("dep_wb", 5'b11000);
    tick(); hz.wb_wr_en = 1'b0; #1;
    chk_ctl("dep_retired", 5'b00000);
    tick(); clr();
    hz.wb_wr_en = 1'b1; hz.wb_wr_reg = 3'd7; hz.dec_src_b = 3'd7; #1;
    chk_ctl("dep_unused_src", 5'b00000);
    hz.dec_use_b = 1'b1; #1;
    chk_ctl("dep_src_b_wb", 5'b11000);
    hz.wb_wr_reg = 3'd6; #1;
    chk_ctl("dep_no_match", 5'b00000);
    hz.wb_wr_reg = 3'd7; hz.branch_taken = 1'b1; #1;
    chk_ctl("dep_branch", 5'b00110);
    hz.branch_taken = 1'b0; #1;
    chk_ctl("dep_before_rst", 5'b11000);
    rst = 1'b1; #1;
    chk_ctl("dep_rst_async", 5'b00000);
    rst = 1'b0;
    tick(); clr(); #1;
    chk_ctl("dep_rst_run", 5'b00000);
`endif

    // Branch beats a wrong-path halt.
    tick(); clr(); hz.dec_halt = 1'b1; hz.branch_taken = 1'b1; #1;
    chk_ctl("halt_branch", 5'b00110);
    tick(); clr(); #1;
    chk_ctl("halt_branch_run", 5'b00000);

    // Halt drain: wb_halt three cycles later, halted the cycle after.
    tick(); clr(); hz.dec_halt = 1'b1; #1;
    chk_ctl("halt_c0", 5'b10000);
    tick(); #1;
    chk_ctl("halt_c1", 5'b10000);
    tick(); #1;
    chk_ctl("halt_c2", 5'b10000);
    tick(); hz.wb_halt = 1'b1; #1;
    chk_ctl("halt_c3_wb", 5'b10000);
    tick(); hz.wb_halt = 1'b0; hz.dec_halt = 1'b0; #1;
    chk_ctl("halted_c4", 5'b10001);
    tick(); hz.branch_taken = 1'b1; #1;
    chk_ctl("halted_sticky", 5'b10001);
    rst = 1'b1; #1;
    chk_ctl("halted_rst", 5'b00000);
    rst = 1'b0;
    tick(); clr(); #1;
    chk_ctl("post_halt_run", 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
